// File: rtl/conv_stream_host.sv
// Streams a host-loaded N-sample vector to a convolution core over x valid/ready
// and collects the L = N-M+1 results from y valid/ready into an addressable buffer.
module conv_stream_host #(
    parameter int N = 16,
    parameter int M = 4,
    parameter int T = 20
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ld_en,
    input  logic [$clog2(N)-1:0]     ld_addr,
    input  logic signed [T-1:0]      ld_data,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic signed [T-1:0]      x_data,
    output logic                     x_valid,
    input  logic                     x_ready,
    input  logic signed [T-1:0]      y_data,
    input  logic                     y_valid,
    output logic                     y_ready,
    input  logic [$clog2(N-M+1)-1:0] rd_addr,
    output logic signed [T-1:0]      rd_data
);
    localparam int L   = N - M + 1;
    localparam int XAW = $clog2(N);
    localparam int YAW = $clog2(L);
    localparam int XCW = XAW + 1;
    localparam int YCW = YAW + 1;
    localparam logic [XCW-1:0] X_END = XCW'(N);
    localparam logic [YCW-1:0] Y_END = YCW'(L);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]           state;
    logic [XCW-1:0]       x_cnt;
    logic [YCW-1:0]       y_cnt;
    logic signed [T-1:0]  xbuf [2**XAW];
    logic signed [T-1:0]  ybuf [2**YAW];
    logic                 x_fire;
    logic                 y_fire;

    // Handshake qualifiers depend only on state and counters, so an async
    // reset removes them before the next edge.
    assign x_valid = (state == S_RUN) && (x_cnt < X_END);
    assign y_ready = (state == S_RUN) && (y_cnt < Y_END);
    assign busy    = (state != S_IDLE);
    assign done    = (state == S_DONE);
    assign x_data  = xbuf[x_cnt[XAW-1:0]];
    assign x_fire  = x_valid && x_ready;
    assign y_fire  = y_valid && y_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            x_cnt <= '0;
            y_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_RUN;
                        x_cnt <= '0;
                        y_cnt <= '0;
                    end
                end
                S_RUN: begin
                    if (x_fire) x_cnt <= x_cnt + XCW'(1);
                    if (y_fire) y_cnt <= y_cnt + YCW'(1);
                    if ((x_cnt == X_END) && (y_cnt == Y_END)) state <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Buffers carry no reset; loads are only accepted while idle.
    always_ff @(posedge clk) begin
        if (ld_en && (state == S_IDLE)) xbuf[ld_addr] <= ld_data;
        if (y_fire) ybuf[y_cnt[YAW-1:0]] <= y_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rd_data <= '0;
        else       rd_data <= ybuf[rd_addr];
    end
endmodule

// File: tb/tb_conv_stream_host.sv
// Bench for conv_stream_host: acts as the conv core (x sink, y source) and checks
// the stream, the collected results and the readback against a reference model.
module tb_conv_stream_host;
    localparam int N   = 16;
    localparam int M   = 4;
    localparam int T   = 20;
    localparam int L   = N - M + 1;
    localparam int XAW = $clog2(N);
    localparam int YAW = $clog2(L);

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                ld_en = 1'b0;
    logic [XAW-1:0]      ld_addr = '0;
    logic signed [T-1:0] ld_data = '0;
    logic                start = 1'b0;
    logic                busy, done, x_valid, y_ready;
    logic signed [T-1:0] x_data, rd_data;
    logic                x_ready = 1'b0;
    logic signed [T-1:0] y_data = '0;
    logic                y_valid = 1'b0;
    logic [YAW-1:0]      rd_addr = '0;

    conv_stream_host #(.N(N), .M(M), .T(T)) dut (
        .clk(clk), .reset(reset), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .start(start), .busy(busy), .done(done), .x_data(x_data), .x_valid(x_valid),
        .x_ready(x_ready), .y_data(y_data), .y_valid(y_valid), .y_ready(y_ready),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    int f [M] = '{158, -514, -415, -64};
    logic signed [T-1:0] EXTRA_WORD = 20'sd777;
    logic signed [T-1:0] xm [N];
    logic signed [T-1:0] expv [L];
    logic signed [T-1:0] sent_q [$];
    int  n_vec = 0, n_bad = 0;
    int  xmode = 0, cyc = 0, y_idx = 0, done_seen = 0;
    bit  ygap = 0, extra = 0, agent_on = 0, y_pend = 0;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic signed [T-1:0] relu_dot(input int w [M]);
        int acc = 0;
        for (int k = 0; k < M; k++) acc += f[k] * w[k];
        return (acc < 0) ? '0 : T'(acc);
    endfunction

    // Core stand-in: consumes x beats, offers result i once x[i..i+M-1] arrived.
    always @(negedge clk) begin
        int w [M];
        int avail;
        if (reset || !agent_on) begin
            x_ready = 1'b0;
            y_valid = 1'b0;
            y_pend  = 1'b0;
        end else begin
            if (busy && !done) begin
                check_eq("x_valid", x_valid, sent_q.size() < N);
                check_eq("y_ready", y_ready, y_idx < L);
                if (x_valid && sent_q.size() < N) check_eq("x_head", x_data, xm[sent_q.size()]);
            end
            if (done) done_seen++;
            avail = sent_q.size() - M + 1;
            if (!y_pend) begin
                if (y_idx < L && y_idx < avail && (!ygap || $urandom_range(0, 1) == 1)) begin
                    for (int k = 0; k < M; k++) w[k] = int'(sent_q[y_idx + k]);
                    y_valid = 1'b1;
                    y_data  = relu_dot(w);
                end else if (extra && y_idx >= L) begin
                    y_valid = 1'b1;
                    y_data  = EXTRA_WORD;
                end else begin
                    y_valid = 1'b0;
                end
            end
            if (y_valid && y_ready) begin
                y_idx++;
                y_pend = 1'b0;
            end else begin
                y_pend = y_valid;
            end
            case (xmode)
                0:       x_ready = 1'b1;
                1:       x_ready = (cyc % 3 == 0);
                default: x_ready = ($urandom_range(0, 3) != 0);
            endcase
            cyc++;
            if (x_valid && x_ready) sent_q.push_back(x_data);
        end
    end

    task automatic load_all();
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            ld_en = 1'b1; ld_addr = XAW'(i); ld_data = xm[i];
        end
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic fill_random();
        int v;
        for (int i = 0; i < N; i++) begin
            v = int'($urandom_range(0, 510)) - 255;
            xm[i] = T'(v);
        end
    endtask

    task automatic readback();
        for (int a = 0; a < L; a++) begin
            @(negedge clk);
            rd_addr = YAW'(a);
            #1;
            if (a > 0) check_eq("rd_latency", rd_data, expv[a-1]);
            @(negedge clk);
            check_eq("rd_data", rd_data, expv[a]);
        end
    endtask

    task automatic do_run(input int mode, input bit gap, input bit ext, input bit disturb,
                          input bit edge_ld, input int reset_at);
        int w [M];
        int t;
        xmode = mode; ygap = gap; extra = ext;
        sent_q.delete();
        y_idx = 0; done_seen = 0; cyc = 0; y_pend = 1'b0;
        agent_on = 1'b1;
        @(negedge clk);
        start = 1'b1;
        if (edge_ld) begin
            xm[0] = T'(int'($urandom_range(0, 200)) - 100);
            ld_en = 1'b1; ld_addr = '0; ld_data = xm[0];
        end
        @(negedge clk);
        start = 1'b0; ld_en = 1'b0;
        for (int i = 0; i < L; i++) begin
            for (int k = 0; k < M; k++) w[k] = int'(xm[i + k]);
            expv[i] = relu_dot(w);
        end
        if (disturb) begin
            repeat (2) @(negedge clk);
            start = 1'b1; ld_en = 1'b1; ld_addr = XAW'(3); ld_data = 20'sd999;
            @(negedge clk);
            start = 1'b0; ld_en = 1'b0;
        end
        if (reset_at > 0) begin
            for (t = 0; t < 500 && sent_q.size() < reset_at; t++) @(negedge clk);
            check_eq("reach_beat", sent_q.size() >= reset_at, 1);
            #2 reset = 1'b1;
            #1;
            check_eq("rst_x_valid", x_valid, 0);
            check_eq("rst_y_ready", y_ready, 0);
            check_eq("rst_busy", busy, 0);
            agent_on = 1'b0;
            repeat (2) @(negedge clk);
            reset = 1'b0;
            return;
        end
        for (t = 0; t < 600; t++) begin
            @(negedge clk);
            if (done) break;
        end
        check_eq("done_in_time", done, 1);
        repeat (4) @(negedge clk);
        check_eq("done_pulses", done_seen, 1);
        check_eq("x_beats", sent_q.size(), N);
        for (int i = 0; i < N && i < sent_q.size(); i++) check_eq("x_order", sent_q[i], xm[i]);
        check_eq("y_accepted", y_idx, L);
        check_eq("busy_after", busy, 0);
        agent_on = 1'b0;
        readback();
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("reset_busy", busy, 0);
        check_eq("reset_done", done, 0);
        check_eq("reset_x_valid", x_valid, 0);
        check_eq("reset_y_ready", y_ready, 0);
        check_eq("reset_rd_data", rd_data, 0);
        reset = 1'b0;

        // All -1: every result 835
        foreach (xm[i]) xm[i] = -20'sd1;
        load_all();
        do_run(0, 0, 0, 0, 0, 0);
        @(negedge clk); rd_addr = YAW'(5);
        @(negedge clk); check_eq("all_m1_835", rd_data, 835);

        // All +1: ReLU clamps to 0
        foreach (xm[i]) xm[i] = 20'sd1;
        load_all();
        do_run(0, 0, 0, 0, 0, 0);
        @(negedge clk); rd_addr = YAW'(7);
        @(negedge clk); check_eq("all_p1_zero", rd_data, 0);

        // Ramp with x_ready pattern 1,0,0
        foreach (xm[i]) xm[i] = T'(i);
        load_all();
        do_run(1, 0, 0, 0, 0, 0);

        // Random data, gappy y source with a 14th word offered
        fill_random();
        load_all();
        do_run(0, 1, 1, 0, 0, 0);

        // start/ld_en during RUN ignored, then rerun without reloading
        foreach (xm[i]) xm[i] = T'(i);
        load_all();
        do_run(0, 0, 0, 1, 0, 0);
        do_run(2, 1, 0, 0, 0, 0);

        // Reset at beat 7, then a fresh run
        fill_random();
        load_all();
        do_run(0, 0, 0, 0, 0, 7);
        do_run(0, 0, 0, 0, 0, 0);

        for (int r = 0; r < 3; r++) begin
            fill_random();
            load_all();
            do_run(2, 1, r == 0, 0, r == 1, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
